// File: rtl/wb_io_pkg.sv
// Register map and shared helpers for the Wishbone GPIO controller.
package wb_io_pkg;

  localparam int WIN_BYTES = 64;
  localparam int WIN_LSB   = $clog2(WIN_BYTES);

  localparam logic [3:0] OUT_LO  = 4'd0;
  localparam logic [3:0] OUT_HI  = 4'd1;
  localparam logic [3:0] OEB_LO  = 4'd2;
  localparam logic [3:0] OEB_HI  = 4'd3;
  localparam logic [3:0] IN_LO   = 4'd4;
  localparam logic [3:0] IN_HI   = 4'd5;
  localparam logic [3:0] IEN_LO  = 4'd6;
  localparam logic [3:0] IEN_HI  = 4'd7;
  localparam logic [3:0] PEND_LO = 4'd8;
  localparam logic [3:0] PEND_HI = 4'd9;
  localparam logic [3:0] EDGE_LO = 4'd10;
  localparam logic [3:0] EDGE_HI = 4'd11;

  typedef enum logic [3:0] {
    IDX_OUT_LO  = OUT_LO,
    IDX_OUT_HI  = OUT_HI,
    IDX_OEB_LO  = OEB_LO,
    IDX_OEB_HI  = OEB_HI,
    IDX_IN_LO   = IN_LO,
    IDX_IN_HI   = IN_HI,
    IDX_IEN_LO  = IEN_LO,
    IDX_IEN_HI  = IEN_HI,
    IDX_PEND_LO = PEND_LO,
    IDX_PEND_HI = PEND_HI,
    IDX_EDGE_LO = EDGE_LO,
    IDX_EDGE_HI = EDGE_HI
  } reg_idx_e;

  // Byte-lane merge of write data into a 64-bit register image.
  function automatic logic [63:0] merge_bits(input logic [63:0] cur,
                                             input logic [63:0] wdata,
                                             input logic [63:0] wmask);
    return (cur & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Pad input synchroniser with a delayed copy and rise/fall event vectors.
module io_sync_edge #(
  parameter int WIDTH       = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES*WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]             prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[(SYNC_STAGES-1)*WIDTH-1:0], din};
      prev_reg  <= sync;
    end
  end

  assign sync = chain_reg[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/wb_io_ctrl.sv
// Wishbone-mapped GPIO block: pad outputs/enables, synchronised inputs,
// per-pad edge interrupts with write-1-to-clear pending bits.
module wb_io_ctrl
  import wb_io_pkg::*;
#(
  parameter int          NUM_IO      = 38,
  parameter int          NUM_IRQ     = 3,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic [31:0]        wbs_dat_o,
  output logic               wbs_ack_o,
  input  logic [NUM_IO-1:0]  io_in,
  output logic [NUM_IO-1:0]  io_out,
  output logic [NUM_IO-1:0]  io_oeb,
  output logic [NUM_IRQ-1:0] user_irq
);

  localparam logic [63:0] IO_MASK = {64{1'b1}} >> (64 - NUM_IO);
  localparam logic [2:0]  SETTLE  = 3'(SYNC_STAGES + 1);

  logic [63:0]        out_reg, oeb_reg, ien_reg, pend_reg, edge_reg;
  logic [63:0]        pend_next, in_view, edge_evt, wmask, wdata;
  logic [31:0]        lane_mask, rdata, dat_reg;
  logic               ack_reg, hit, acc, wr, detect_en, unused_adr;
  logic [2:0]         settle_reg;
  logic [NUM_IRQ-1:0] irq_reg, irq_next;
  logic [NUM_IO-1:0]  in_sync, in_rise, in_fall;

  assign hit       = (wbs_adr_i[31:WIN_LSB] == BASE_ADR[31:WIN_LSB]);
  assign acc       = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
  assign wr        = acc & wbs_we_i;
  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask     = wbs_adr_i[2] ? {lane_mask, 32'h0} : {32'h0, lane_mask};
  assign wdata     = {wbs_dat_i, wbs_dat_i};
  assign unused_adr = ^wbs_adr_i[1:0];

  io_sync_edge #(
    .WIDTH       (NUM_IO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (io_in),
    .sync (in_sync),
    .rise (in_rise),
    .fall (in_fall)
  );

  // Edge detection is held off until the synchroniser has refilled after reset.
  assign detect_en = (settle_reg == SETTLE);

  genvar gi, gk;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bit
      if (gi < NUM_IO) begin : g_pad
        assign in_view[gi]  = in_sync[gi];
        assign edge_evt[gi] = detect_en & oeb_reg[gi] &
                              (edge_reg[gi] ? in_rise[gi] : in_fall[gi]);
      end else begin : g_none
        assign in_view[gi]  = 1'b0;
        assign edge_evt[gi] = 1'b0;
      end
    end

    for (gk = 0; gk < NUM_IRQ; gk++) begin : g_irq
      logic [63:0] grp;
      for (gi = 0; gi < 64; gi++) begin : g_tap
        assign grp[gi] = ((gi % NUM_IRQ) == gk) ? (pend_reg[gi] & ien_reg[gi]) : 1'b0;
      end
      assign irq_next[gk] = |grp;
    end
  endgenerate

  always_comb begin
    rdata = 32'h0;
    case (wbs_adr_i[5:2])
      IDX_OUT_LO:  rdata = out_reg[31:0];
      IDX_OUT_HI:  rdata = out_reg[63:32];
      IDX_OEB_LO:  rdata = oeb_reg[31:0];
      IDX_OEB_HI:  rdata = oeb_reg[63:32];
      IDX_IN_LO:   rdata = in_view[31:0];
      IDX_IN_HI:   rdata = in_view[63:32];
      IDX_IEN_LO:  rdata = ien_reg[31:0];
      IDX_IEN_HI:  rdata = ien_reg[63:32];
      IDX_PEND_LO: rdata = pend_reg[31:0];
      IDX_PEND_HI: rdata = pend_reg[63:32];
      IDX_EDGE_LO: rdata = edge_reg[31:0];
      IDX_EDGE_HI: rdata = edge_reg[63:32];
      default:     rdata = 32'h0;
    endcase
  end

  // Clear first, then OR in new events so a coincident edge wins over W1C.
  always_comb begin
    pend_next = pend_reg;
    if (wr && (wbs_adr_i[5:2] == IDX_PEND_LO || wbs_adr_i[5:2] == IDX_PEND_HI))
      pend_next = pend_next & ~(wmask & wdata);
    pend_next = (pend_next | edge_evt) & IO_MASK;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_reg    <= '0;
      oeb_reg    <= IO_MASK;
      ien_reg    <= '0;
      pend_reg   <= '0;
      edge_reg   <= IO_MASK;
      ack_reg    <= 1'b0;
      dat_reg    <= '0;
      irq_reg    <= '0;
      settle_reg <= '0;
    end else begin
      ack_reg  <= acc;
      dat_reg  <= acc ? rdata : 32'h0;
      pend_reg <= pend_next;
      irq_reg  <= irq_next;
      if (!detect_en)
        settle_reg <= settle_reg + 3'd1;
      if (wr) begin
        case (wbs_adr_i[5:2])
          IDX_OUT_LO, IDX_OUT_HI:   out_reg  <= merge_bits(out_reg,  wdata, wmask) & IO_MASK;
          IDX_OEB_LO, IDX_OEB_HI:   oeb_reg  <= merge_bits(oeb_reg,  wdata, wmask) & IO_MASK;
          IDX_IEN_LO, IDX_IEN_HI:   ien_reg  <= merge_bits(ien_reg,  wdata, wmask) & IO_MASK;
          IDX_EDGE_LO, IDX_EDGE_HI: edge_reg <= merge_bits(edge_reg, wdata, wmask) & IO_MASK;
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign io_out    = out_reg[NUM_IO-1:0];
  assign io_oeb    = oeb_reg[NUM_IO-1:0];
  assign user_irq  = irq_reg;

endmodule

// File: tb/tb_wb_io_ctrl.sv
// Directed bench for wb_io_ctrl: a default 38-pad build and an 8-pad/1-irq build.
module tb_wb_io_ctrl;
  import wb_io_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, tgt = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_w = 32'h0;
  logic [31:0] dat0, dat1, dat_r;
  logic        ack0, ack1, ack;

  logic [37:0] io_in = 38'h0;
  logic [37:0] io_out, io_oeb;
  logic [2:0]  irq;
  logic [7:0]  io_in8 = 8'h0;
  logic [7:0]  io_out8, io_oeb8;
  logic [0:0]  irq8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign ack   = tgt ? ack1 : ack0;
  assign dat_r = tgt ? dat1 : dat0;

  wb_io_ctrl dut (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_cyc_i (cyc & ~tgt), .wbs_stb_i (stb), .wbs_we_i (we),
    .wbs_sel_i (sel), .wbs_adr_i (adr), .wbs_dat_i (dat_w),
    .wbs_dat_o (dat0), .wbs_ack_o (ack0),
    .io_in (io_in), .io_out (io_out), .io_oeb (io_oeb), .user_irq (irq)
  );

  wb_io_ctrl #(.NUM_IO(8), .NUM_IRQ(1)) dut8 (
    .wb_clk_i (clk), .wb_rst_i (rst),
    .wbs_cyc_i (cyc & tgt), .wbs_stb_i (stb), .wbs_we_i (we),
    .wbs_sel_i (sel), .wbs_adr_i (adr), .wbs_dat_i (dat_w),
    .wbs_dat_o (dat1), .wbs_ack_o (ack1),
    .io_in (io_in8), .io_out (io_out8), .io_oeb (io_oeb8), .user_irq (irq8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] ra(input logic [3:0] idx);
    return BASE | {26'h0, idx, 2'b00};
  endfunction

  // Strobe is held through the ack cycle to confirm it does not start a second access.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic acked);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    acked = 1'b0; rd = 32'h0; n = 0;
    while (!acked && n < 8) begin
      @(posedge clk); #1; n++;
      if (ack) begin acked = 1'b1; rd = dat_r; end
    end
    if (acked) begin
      check("ack_lat", n, 1);
      @(posedge clk); #1;
      check("ack_width", ack, 1'b0);
      check("dat_idle", dat_r, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("wb %s adr=0x%08h dat=0x%08h sel=%b ack=%0b rd=0x%08h",
             w ? "WR" : "RD", a, d, s, acked, rd);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic        acked;
    wb_xfer(1'b1, a, d, s, rd, acked);
    check("wr_acked", acked, 1'b1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    logic acked;
    wb_xfer(1'b0, a, 32'h0, 4'hF, rd, acked);
    check("rd_acked", acked, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        acked;
    int          c;

    // Reset is asynchronous: values must appear before any clock edge.
    io_in = 38'h2;
    #2 rst = 1'b1;
    #1;
    check("rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    check("rst_out", io_out, 38'h0);
    check("rst_irq", irq, 3'b000);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_r, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pad 1 high through reset must not raise PEND.
    repeat (6) @(posedge clk);
    wb_read(ra(PEND_LO), rd); check("pend_after_rst", rd, 32'h0);
    wb_read(ra(IN_LO), rd);   check("in_lo", rd, 32'h2);

    // Byte-lane writes and bits above NUM_IO.
    wb_write(ra(OUT_LO), 32'hA5A5_5A5A, 4'hF);
    wb_write(ra(OUT_HI), 32'hFFFF_FFFF, 4'b0001);
    check("io_out_hi", io_out, {6'h3F, 32'hA5A5_5A5A});
    wb_read(ra(OUT_HI), rd); check("out_hi_rb", rd, 32'h0000_003F);
    wb_write(ra(OUT_LO), 32'h1122_3344, 4'b0100);
    wb_read(ra(OUT_LO), rd); check("out_lo_lane", rd, 32'hA522_5A5A);
    wb_read(ra(OEB_HI), rd); check("oeb_hi_def", rd, 32'h0000_003F);
    wb_read(ra(EDGE_HI), rd); check("edge_hi_def", rd, 32'h0000_003F);

    // Rising edge on pad 0 -> PEND[0] -> user_irq[0].
    wb_write(ra(IEN_LO), 32'h1, 4'hF);
    @(posedge clk); #1; io_in[0] = 1'b1;
    c = 0;
    while (c < 8 && !irq[0]) begin @(posedge clk); #1; c++; end
    check("irq_lat", c, 4);
    check("irq_vec", irq, 3'b001);
    wb_read(ra(PEND_LO), rd); check("pend_rise", rd, 32'h1);

    // Pad 4 maps to user_irq[1].
    wb_write(ra(IEN_LO), 32'h11, 4'hF);
    @(posedge clk); #1; io_in[4] = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("irq_grp", irq, 3'b011);
    wb_write(ra(PEND_LO), 32'h10, 4'hF);
    wb_read(ra(PEND_LO), rd); check("pend_w1c", rd, 32'h1);
    check("irq_after_w1c", irq, 3'b001);

    // W1C of bit 0 lands on the same edge as a new rising edge: set wins.
    io_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1; io_in[0] = 1'b1;
    @(posedge clk);
    wb_write(ra(PEND_LO), 32'h1, 4'hF);
    wb_read(ra(PEND_LO), rd); check("pend_set_wins", rd, 32'h1);
    wb_write(ra(PEND_LO), 32'h1, 4'hF);
    wb_read(ra(PEND_LO), rd); check("pend_clr", rd, 32'h0);
    check("irq_clr", irq, 3'b000);

    // Changing EDGE alone does not create events.
    wb_write(ra(EDGE_LO), 32'h0, 4'hF);
    wb_read(ra(PEND_LO), rd); check("pend_edge_wr", rd, 32'h0);
    wb_write(ra(EDGE_LO), 32'hFFFF_FFFF, 4'hF);
    wb_read(ra(IN_LO), rd); check("in_lo2", rd, 32'h13);
    wb_read(ra(IN_HI), rd); check("in_hi", rd, 32'h0);

    // Address decode and reserved slots.
    wb_xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, rd, acked);
    check("oor_noack", acked, 1'b0);
    wb_xfer(1'b0, BASE + 32'h30, 32'h0, 4'hF, rd, acked);
    check("rsv_ack", acked, 1'b1);
    check("rsv_dat", rd, 32'h0);
    wb_write(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h3C, rd); check("rsv_rd", rd, 32'h0);

    // Reset between strobe and ack aborts the write.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = ra(OUT_LO); dat_w = 32'hFFFF_FFFF; sel = 4'hF;
    #3 rst = 1'b1;
    #1;
    check("abort_ack", ack, 1'b0);
    check("abort_out", io_out, 38'h0);
    check("abort_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    @(posedge clk); #1;
    check("abort_ack2", ack, 1'b0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    wb_read(ra(OUT_LO), rd);  check("abort_out_rb", rd, 32'h0);
    wb_read(ra(PEND_LO), rd); check("pend_after_rst2", rd, 32'h0);
    wb_write(ra(OUT_LO), 32'h0000_1234, 4'hF);
    check("post_rst_out", io_out, 38'h1234);

    // Narrow build: NUM_IO=8, NUM_IRQ=1.
    tgt = 1'b1;
    wb_write(ra(OEB_LO), 32'h0, 4'hF);
    @(posedge clk); #1; io_in8[3] = 1'b1; io_in8[7] = 1'b1;
    repeat (5) @(posedge clk);
    wb_read(ra(PEND_LO), rd); check("n8_pend_out", rd, 32'h0);
    wb_write(ra(OEB_LO), 32'hFFFF_FFFF, 4'hF);
    wb_read(ra(OEB_LO), rd); check("n8_oeb_mask", rd, 32'hFF);
    check("n8_io_oeb", io_oeb8, 8'hFF);
    wb_write(ra(EDGE_LO), 32'h0, 4'hF);
    wb_write(ra(IEN_LO), 32'hFF, 4'hF);
    @(posedge clk); #1; io_in8[3] = 1'b0; io_in8[7] = 1'b0;
    repeat (5) @(posedge clk);
    wb_read(ra(PEND_LO), rd); check("n8_pend_fall", rd, 32'h88);
    check("n8_irq", irq8, 1'b1);
    wb_read(ra(IN_HI), rd); check("n8_in_hi", rd, 32'h0);
    tgt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
